mem_stage: RTL and testbench

Memory-access / writeback stage that sits directly downstream of the ALU stage. It consumes the ALU stage's registered 42-bit control bundle, performs byte or word loads and stores on a 16-bit little-endian memory bus, and splits unaligned word accesses into two byte accesses. It then issues the register-file write and PC write for the instruction, and holds `busy` high until the instruction retires, so the control unit can stall the pipeline.

---
 rtl/nqcpu_pkg.sv | 53 +++++
 rtl/mem_lane_align.sv | 51 +++++
 rtl/mem_stage.sv | 210 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/nqcpu_pkg.sv
// Shared definitions for the nqcpu pipeline: the ALU->mem control bundle,
// the mem-stage state encoding and the lane-steering phases.
package nqcpu_pkg;

  localparam int unsigned BUNDLE_W = 42;

  // MSB-first field order matches the bundle layout [41:0].
  typedef struct packed {
    logic [15:0] data;         // [41:26]
    logic [1:0]  reg_write;    // [25:24] {H,L}
    logic [2:0]  reg_dest;     // [23:21]
    logic        set_pc;       // [20]
    logic        mem_rd_word;  // [19]
    logic        mem_rd;       // [18]
    logic        mem_wr_word;  // [17]
    logic        mem_wr;       // [16]
    logic [15:0] mem_addr;     // [15:0]
  } alu_mem_bundle_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_WB   = 2'd3
  } mem_state_t;

  typedef enum logic [1:0] {
    PH_BYTE   = 2'd0,
    PH_WORD   = 2'd1,
    PH_ODD_HI = 2'd2,
    PH_ODD_LO = 2'd3
  } lane_phase_t;

  function automatic logic is_mem_op(input alu_mem_bundle_t b);
    return b.mem_rd | b.mem_wr;
  endfunction

  // A write wins over a simultaneous read, so its width is the one that counts.
  function automatic logic is_word_op(input alu_mem_bundle_t b);
    return b.mem_wr ? b.mem_wr_word : b.mem_rd_word;
  endfunction

  function automatic logic is_split_op(input alu_mem_bundle_t b);
    return is_word_op(b) & b.mem_addr[0];
  endfunction

  function automatic lane_phase_t first_phase(input alu_mem_bundle_t b);
    if (!is_word_op(b))   return PH_BYTE;
    else if (b.mem_addr[0]) return PH_ODD_HI;
    else                  return PH_WORD;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: word address, byte enables and write-data
// replication for one bus access, plus read-lane selection.
module mem_lane_align
  import nqcpu_pkg::*;
(
  input  lane_phase_t phase_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic [1:0]  rd_be_i,
  input  logic [15:0] rdata_i,
  output logic [14:0] waddr_o,
  output logic [1:0]  be_o,
  output logic [15:0] wdata_o,
  output logic [7:0]  rd_byte_o
);

  logic [15:0] addr_inc;

  // Second half of an odd word wraps 0xFFFF -> 0x0000 by plain 16-bit overflow.
  assign addr_inc = addr_i + 16'd1;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    waddr_o = addr_i[15:1];
    be_o    = 2'b00;
    wdata_o = '0;
    case (phase_i)
      PH_BYTE: begin
        be_o    = addr_i[0] ? 2'b10 : 2'b01;
        wdata_o = {wdata_i[7:0], wdata_i[7:0]};
      end
      PH_WORD: begin
        be_o    = 2'b11;
        wdata_o = wdata_i;
      end
      PH_ODD_HI: begin
        be_o    = 2'b10;
        wdata_o = {wdata_i[7:0], wdata_i[7:0]};
      end
      PH_ODD_LO: begin
        waddr_o = addr_inc[15:1];
        be_o    = 2'b01;
        wdata_o = {wdata_i[15:8], wdata_i[15:8]};
      end
      default: ;
    endcase
  end

  assign rd_byte_o = (rd_be_i == 2'b10) ? rdata_i[15:8] : rdata_i[7:0];

endmodule

// File: rtl/mem_stage.sv
// Memory-access / writeback stage: byte/word loads and stores on a 16-bit
// little-endian bus, odd-word splitting, and register-file / PC writeback.
module mem_stage
  import nqcpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [BUNDLE_W-1:0] ctrl_in,
  output logic                busy,
  output logic                done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [14:0]         mem_waddr,
  output logic [1:0]          mem_be,
  output logic [15:0]         mem_wdata,
  input  logic [15:0]         mem_rdata,
  input  logic                mem_ack,
  output logic [1:0]          rf_we,
  output logic [2:0]          rf_dest,
  output logic [15:0]         rf_data,
  output logic                pc_set,
  output logic [15:0]         pc_value
);

  alu_mem_bundle_t ctrl;
  assign ctrl = ctrl_in;

  mem_state_t      state_q, state_d;
  alu_mem_bundle_t op_q, op_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [14:0]     waddr_q, waddr_d;
  logic [1:0]      be_q, be_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [7:0]      hi_byte_q, hi_byte_d;
  logic            done_q, done_d;
  logic [1:0]      rf_we_q, rf_we_d;
  logic [2:0]      rf_dest_q, rf_dest_d;
  logic [15:0]     rf_data_q, rf_data_d;
  logic            pc_set_q, pc_set_d;
  logic [15:0]     pc_value_q, pc_value_d;

  lane_phase_t     al_phase;
  logic [15:0]     al_addr, al_data;
  logic [14:0]     al_waddr;
  logic [1:0]      al_be;
  logic [15:0]     al_wdata;
  logic [7:0]      al_rd_byte;

  // In IDLE the aligner programs the first access from the incoming bundle;
  // afterwards it only ever needs to produce the second half of a split.
  always_comb begin
    al_phase = PH_ODD_LO;
    al_addr  = op_q.mem_addr;
    al_data  = op_q.data;
    if (state_q == ST_IDLE) begin
      al_phase = first_phase(ctrl);
      al_addr  = ctrl.mem_addr;
      al_data  = ctrl.data;
    end
  end

  mem_lane_align u_align (
    .phase_i   (al_phase),
    .addr_i    (al_addr),
    .wdata_i   (al_data),
    .rd_be_i   (be_q),
    .rdata_i   (mem_rdata),
    .waddr_o   (al_waddr),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .rd_byte_o (al_rd_byte)
  );

  alu_mem_bundle_t wb_src;
  logic            retire;
  logic [15:0]     result;
  logic [15:0]     wb_value;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    req_d      = req_q;
    we_d       = we_q;
    waddr_d    = waddr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    hi_byte_d  = hi_byte_q;
    done_d     = 1'b0;
    rf_we_d    = '0;
    rf_dest_d  = '0;
    rf_data_d  = '0;
    pc_set_d   = 1'b0;
    pc_value_d = '0;
    retire     = 1'b0;
    result     = '0;
    wb_src     = (state_q == ST_IDLE) ? ctrl : op_q;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          op_d = ctrl;
          if (is_mem_op(ctrl)) begin
            state_d = ST_ACC1;
            req_d   = 1'b1;
            we_d    = ctrl.mem_wr;
            waddr_d = al_waddr;
            be_d    = al_be;
            wdata_d = al_wdata;
          end else begin
            retire = 1'b1;
          end
        end
      end
      ST_ACC1: begin
        if (mem_ack) begin
          if (is_split_op(op_q)) begin
            // Keep the request up and move straight to the second byte.
            state_d   = ST_ACC2;
            hi_byte_d = al_rd_byte;
            waddr_d   = al_waddr;
            be_d      = al_be;
            wdata_d   = al_wdata;
          end else begin
            retire = 1'b1;
            result = is_word_op(op_q) ? mem_rdata : {al_rd_byte, al_rd_byte};
          end
        end
      end
      ST_ACC2: begin
        if (mem_ack) begin
          retire = 1'b1;
          result = {al_rd_byte, hi_byte_q};
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    wb_value = (wb_src.mem_rd && !wb_src.mem_wr) ? result : wb_src.data;

    if (retire) begin
      state_d    = ST_WB;
      req_d      = 1'b0;
      we_d       = 1'b0;
      waddr_d    = '0;
      be_d       = '0;
      wdata_d    = '0;
      done_d     = 1'b1;
      rf_we_d    = wb_src.reg_write;
      rf_dest_d  = wb_src.reg_dest;
      rf_data_d  = wb_value;
      pc_set_d   = wb_src.set_pc;
      pc_value_d = wb_value;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values computed in the combinational block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      hi_byte_q  <= '0;
      done_q     <= 1'b0;
      rf_we_q    <= '0;
      rf_dest_q  <= '0;
      rf_data_q  <= '0;
      pc_set_q   <= 1'b0;
      pc_value_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      req_q      <= req_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      hi_byte_q  <= hi_byte_d;
      done_q     <= done_d;
      rf_we_q    <= rf_we_d;
      rf_dest_q  <= rf_dest_d;
      rf_data_q  <= rf_data_d;
      pc_set_q   <= pc_set_d;
      pc_value_q <= pc_value_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign rf_we     = rf_we_q;
  assign rf_dest   = rf_dest_q;
  assign rf_data   = rf_data_q;
  assign pc_set    = pc_set_q;
  assign pc_value  = pc_value_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage with a hand-written bus responder
// and separate sequences for en-while-busy and reset during a split access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [41:0] ctrl_in;
  logic        busy, done, mem_req, mem_we;
  logic [14:0] mem_waddr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  rf_we;
  logic [2:0]  rf_dest;
  logic [15:0] rf_data;
  logic        pc_set;
  logic [15:0] pc_value;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .ctrl_in   (ctrl_in),
    .busy      (busy),
    .done      (done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .rf_we     (rf_we),
    .rf_dest   (rf_dest),
    .rf_data   (rf_data),
    .pc_set    (pc_set),
    .pc_value  (pc_value)
  );

  typedef struct {
    string       name;
    logic [41:0] ctrl;
    logic        mem;
    logic        split;
    int          waits;
    logic [15:0] rd1, rd2;
    logic        we;
    logic [14:0] wa1, wa2;
    logic [1:0]  be1, be2;
    logic [15:0] wd1, wd2;
    logic [1:0]  rfwe;
    logic [2:0]  dest;
    logic [15:0] res;
    logic        pcs;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [41:0] mk(input logic [15:0] d, input logic [1:0] rw,
                                     input logic [2:0] dest, input logic spc,
                                     input logic rdw, input logic rd,
                                     input logic wrw, input logic wr,
                                     input logic [15:0] a);
    return {d, rw, dest, spc, rdw, rd, wrw, wr, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".busy"},      32'(busy),      0);
    check({tag, ".done"},      32'(done),      0);
    check({tag, ".mem_req"},   32'(mem_req),   0);
    check({tag, ".mem_we"},    32'(mem_we),    0);
    check({tag, ".mem_waddr"}, 32'(mem_waddr), 0);
    check({tag, ".mem_be"},    32'(mem_be),    0);
    check({tag, ".mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, ".rf_we"},     32'(rf_we),     0);
    check({tag, ".rf_dest"},   32'(rf_dest),   0);
    check({tag, ".rf_data"},   32'(rf_data),   0);
    check({tag, ".pc_set"},    32'(pc_set),    0);
    check({tag, ".pc_value"},  32'(pc_value),  0);
  endtask

  task automatic check_bus(input string tag, input logic we, input logic [14:0] wa,
                           input logic [1:0] be, input logic [15:0] wd);
    check({tag, ".mem_req"},   32'(mem_req),   1);
    check({tag, ".mem_we"},    32'(mem_we),    32'(we));
    check({tag, ".mem_waddr"}, 32'(mem_waddr), 32'(wa));
    check({tag, ".mem_be"},    32'(mem_be),    32'(be));
    if (we) check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(wd));
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    ctrl_in = v.ctrl;
    en      = 1'b1;
    @(negedge clk);
    en      = 1'b0;
    ctrl_in = '0;
    if (v.mem) begin
      for (int w = 0; w <= v.waits; w++) begin
        if (w > 0) @(negedge clk);
        check_bus({v.name, ".acc1"}, v.we, v.wa1, v.be1, v.wd1);
        check({v.name, ".acc1.busy"}, 32'(busy), 1);
      end
      mem_ack   = 1'b1;
      mem_rdata = v.rd1;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (v.split) begin
        check_bus({v.name, ".acc2"}, v.we, v.wa2, v.be2, v.wd2);
        mem_ack   = 1'b1;
        mem_rdata = v.rd2;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
      end
    end
    check({v.name, ".wb.mem_req"},  32'(mem_req),  0);
    check({v.name, ".wb.busy"},     32'(busy),     1);
    check({v.name, ".wb.done"},     32'(done),     1);
    check({v.name, ".wb.rf_we"},    32'(rf_we),    32'(v.rfwe));
    check({v.name, ".wb.rf_dest"},  32'(rf_dest),  32'(v.dest));
    check({v.name, ".wb.rf_data"},  32'(rf_data),  32'(v.res));
    check({v.name, ".wb.pc_set"},   32'(pc_set),   32'(v.pcs));
    check({v.name, ".wb.pc_value"}, 32'(pc_value), 32'(v.res));
    @(negedge clk);
    check({v.name, ".post.busy"},  32'(busy),  0);
    check({v.name, ".post.done"},  32'(done),  0);
    check({v.name, ".post.rf_we"}, 32'(rf_we), 0);
  endtask

  initial begin
    //               name        ctrl                                                   mem split w  rd1       rd2       we wa1       wa2       be1    be2    wd1       wd2       rfwe   dst   res       pcs
    vecs[0] = '{"nonmem",  mk(16'h1234, 2'b11, 3'd5, 0, 0, 0, 0, 0, 16'h0000), 0, 0, 0, 16'h0,    16'h0,    0, 15'h0,    15'h0,    2'b00, 2'b00, 16'h0,    16'h0,    2'b11, 3'd5, 16'h1234, 0};
    vecs[1] = '{"rd_word", mk(16'h0000, 2'b11, 3'd1, 0, 1, 1, 0, 0, 16'h0100), 1, 0, 3, 16'hBEEF, 16'h0,    0, 15'h0080, 15'h0,    2'b11, 2'b00, 16'h0,    16'h0,    2'b11, 3'd1, 16'hBEEF, 0};
    vecs[2] = '{"rd_odd",  mk(16'h0000, 2'b11, 3'd2, 0, 1, 1, 0, 0, 16'h0101), 1, 1, 0, 16'hAA11, 16'h22BB, 0, 15'h0080, 15'h0081, 2'b10, 2'b01, 16'h0,    16'h0,    2'b11, 3'd2, 16'hBBAA, 0};
    vecs[3] = '{"rd_wrap", mk(16'h0000, 2'b01, 3'd3, 0, 1, 1, 0, 0, 16'hFFFF), 1, 1, 1, 16'hAA11, 16'h22BB, 0, 15'h7FFF, 15'h0000, 2'b10, 2'b01, 16'h0,    16'h0,    2'b01, 3'd3, 16'hBBAA, 0};
    vecs[4] = '{"wr_byte", mk(16'h5A77, 2'b00, 3'd0, 0, 0, 0, 0, 1, 16'h0203), 1, 0, 0, 16'h0,    16'h0,    1, 15'h0101, 15'h0,    2'b10, 2'b00, 16'h7777, 16'h0,    2'b00, 3'd0, 16'h5A77, 0};
    vecs[5] = '{"wr_odd",  mk(16'h5A77, 2'b00, 3'd0, 0, 0, 0, 1, 1, 16'h0203), 1, 1, 2, 16'h0,    16'h0,    1, 15'h0101, 15'h0102, 2'b10, 2'b01, 16'h7777, 16'h5A5A, 2'b00, 3'd0, 16'h5A77, 0};
    vecs[6] = '{"ld_pc",   mk(16'h0000, 2'b00, 3'd0, 1, 0, 1, 0, 0, 16'h0010), 1, 0, 0, 16'h00C3, 16'h0,    0, 15'h0008, 15'h0,    2'b01, 2'b00, 16'h0,    16'h0,    2'b00, 3'd0, 16'hC3C3, 1};
    vecs[7] = '{"rdwr",    mk(16'hCAFE, 2'b10, 3'd6, 0, 1, 1, 0, 1, 16'h0400), 1, 0, 1, 16'h1111, 16'h0,    1, 15'h0200, 15'h0,    2'b11, 2'b00, 16'hCAFE, 16'h0,    2'b10, 3'd6, 16'hCAFE, 0};
    vecs[8] = '{"rd_hi",   mk(16'h0000, 2'b10, 3'd7, 0, 0, 1, 0, 0, 16'h0007), 1, 0, 0, 16'h1234, 16'h0,    0, 15'h0003, 15'h0,    2'b10, 2'b00, 16'h0,    16'h0,    2'b10, 3'd7, 16'h1212, 0};
    vecs[7].ctrl[17] = 1'b1;  // write is a word write as well

    rst_n     = 1'b0;
    en        = 1'b0;
    ctrl_in   = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // en asserted while busy (ACC1 and WB) must not start a new op.
    @(negedge clk);
    ctrl_in = vecs[6].ctrl;
    en      = 1'b1;
    @(negedge clk);
    ctrl_in = mk(16'hDEAD, 2'b11, 3'd4, 1, 0, 0, 0, 0, 16'h0000);
    check_bus("en_busy.acc1", 1'b0, 15'h0008, 2'b01, 16'h0);
    mem_ack   = 1'b1;
    mem_rdata = 16'h00C3;
    @(negedge clk);
    mem_ack   = 1'b0;
    check({"en_busy.wb.done"},     32'(done),     1);
    check({"en_busy.wb.pc_value"}, 32'(pc_value), 32'h0000_C3C3);
    check({"en_busy.wb.rf_we"},    32'(rf_we),    0);
    @(negedge clk);
    en = 1'b0;
    check("en_busy.idle.busy", 32'(busy), 0);
    @(negedge clk);
    check("en_busy.after.busy", 32'(busy), 0);
    check("en_busy.after.done", 32'(done), 0);

    // Reset while in ACC2, then a stray ack must not retire anything.
    @(negedge clk);
    ctrl_in = vecs[2].ctrl;
    en      = 1'b1;
    @(negedge clk);
    en        = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'hAA11;
    @(negedge clk);
    mem_ack   = 1'b0;
    check_bus("rst_mid.acc2", 1'b0, 15'h0081, 2'b01, 16'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'h22BB;
    @(negedge clk);
    mem_ack = 1'b0;
    check("rst_mid.late_ack.done", 32'(done),  0);
    check("rst_mid.late_ack.busy", 32'(busy),  0);
    @(negedge clk);
    check("rst_mid.late_ack2.done",  32'(done),  0);
    check("rst_mid.late_ack2.rf_we", 32'(rf_we), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
